// File: rtl/core_scoreboard.sv
// rtl/core_scoreboard.sv - register-hazard scoreboard and issue controller between decode and execute
module core_scoreboard #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_issue_valid,
    output logic        o_issue_ready,
    input  logic [4:0]  i_issue_rd_idx,
    input  logic        i_issue_rd_we,
    input  logic [1:0]  i_issue_rd_src,
    input  logic [4:0]  i_issue_rs1_idx,
    input  logic [4:0]  i_issue_rs2_idx,
    input  logic        i_issue_rs1_used,
    input  logic        i_issue_rs2_used,
    input  logic        i_wb_valid,
    input  logic [4:0]  i_wb_rd_idx,
    input  logic        i_flush,
    output logic [31:0] o_pending_mask,
    output logic [4:0]  o_outstanding,
    output logic        o_stall_raw,
    output logic        o_stall_waw,
    output logic        o_stall_csr,
    output logic        o_stall_full,
    output logic [1:0]  o_stall_src,
    output logic        o_wb_err
);

    // rd_src_e encoding of a CSR read result
    localparam logic [1:0] RD_FROM_CSR = 2'd2;
    localparam logic [4:0] MAX_CNT     = 5'(MAX_OUTSTANDING);

    logic [31:0]      pending_q, pending_d;
    logic [31:0][1:0] tags_q, tags_d;
    logic [4:0]       count_q, count_d;
    logic             csr_pending_q, csr_pending_d;
    logic             wb_err_q, wb_err_d;

    logic rs1_hit, rs2_hit;
    logic issue_wr;
    logic raw_cond, waw_cond, csr_cond, full_cond;
    logic issue_ready, stall_show;
    logic issue_fire, wb_hit;

    // Hazard detection and the issue decision, all from pre-writeback state
    always_comb begin
        rs1_hit     = i_issue_rs1_used && (i_issue_rs1_idx != 5'd0) && pending_q[i_issue_rs1_idx];
        rs2_hit     = i_issue_rs2_used && (i_issue_rs2_idx != 5'd0) && pending_q[i_issue_rs2_idx];
        issue_wr    = i_issue_rd_we && (i_issue_rd_idx != 5'd0);
        raw_cond    = rs1_hit || rs2_hit;
        waw_cond    = issue_wr && pending_q[i_issue_rd_idx];
        csr_cond    = csr_pending_q || ((i_issue_rd_src == RD_FROM_CSR) && (count_q != 5'd0));
        full_cond   = issue_wr && (count_q == MAX_CNT);
        issue_ready = !raw_cond && !waw_cond && !csr_cond && !full_cond && !i_flush && !i_rst;
        stall_show  = i_issue_valid && !issue_ready;
        issue_fire  = i_issue_valid && issue_ready && issue_wr;
        wb_hit      = i_wb_valid && (i_wb_rd_idx != 5'd0) && pending_q[i_wb_rd_idx];
    end

    // Stall cause reporting; rs1 wins when both sources are blocked
    always_comb begin
        o_issue_ready = issue_ready;
        o_stall_raw   = stall_show && raw_cond;
        o_stall_waw   = stall_show && waw_cond;
        o_stall_csr   = stall_show && csr_cond;
        o_stall_full  = stall_show && full_cond;
        o_stall_src   = 2'd0;
        if (o_stall_raw) begin
            if (rs1_hit) begin
                o_stall_src = tags_q[i_issue_rs1_idx];
            end else begin
                o_stall_src = tags_q[i_issue_rs2_idx];
            end
        end
    end

    // Next-state: writeback release, then issue allocation, flush overrides both
    always_comb begin
        pending_d     = pending_q;
        tags_d        = tags_q;
        count_d       = count_q;
        csr_pending_d = csr_pending_q;
        wb_err_d      = i_wb_valid && !wb_hit;

        if (wb_hit) begin
            pending_d[i_wb_rd_idx] = 1'b0;
            if (tags_q[i_wb_rd_idx] == RD_FROM_CSR) begin
                csr_pending_d = 1'b0;
            end
        end

        if (issue_fire) begin
            pending_d[i_issue_rd_idx] = 1'b1;
            tags_d[i_issue_rd_idx]    = i_issue_rd_src;
            if (i_issue_rd_src == RD_FROM_CSR) begin
                csr_pending_d = 1'b1;
            end
        end

        case ({issue_fire, wb_hit})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;
        endcase

        if (i_flush) begin
            pending_d     = 32'd0;
            count_d       = 5'd0;
            csr_pending_d = 1'b0;
        end
    end

    // State register with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pending_q     <= 32'd0;
            tags_q        <= '0;
            count_q       <= 5'd0;
            csr_pending_q <= 1'b0;
            wb_err_q      <= 1'b0;
        end else begin
            pending_q     <= pending_d;
            tags_q        <= tags_d;
            count_q       <= count_d;
            csr_pending_q <= csr_pending_d;
            wb_err_q      <= wb_err_d;
        end
    end

    assign o_pending_mask = pending_q;
    assign o_outstanding  = count_q;
    assign o_wb_err       = wb_err_q;

endmodule

// File: tb/tb_core_scoreboard.sv
// tb/tb_core_scoreboard.sv - directed table-driven bench for core_scoreboard
module tb_core_scoreboard;

    localparam logic [1:0] ALU  = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] CSR  = 2'd2;
    localparam logic [1:0] PC4  = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic        issue_ready;
    logic [4:0]  rd_idx;
    logic        rd_we;
    logic [1:0]  rd_src;
    logic [4:0]  rs1_idx, rs2_idx;
    logic        rs1_used, rs2_used;
    logic        wb_valid;
    logic [4:0]  wb_idx;
    logic        flush;
    logic [31:0] pending_mask;
    logic [4:0]  outstanding;
    logic        stall_raw, stall_waw, stall_csr, stall_full;
    logic [1:0]  stall_src;
    logic        wb_err;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    core_scoreboard #(.MAX_OUTSTANDING(4)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_issue_valid    (issue_valid),
        .o_issue_ready    (issue_ready),
        .i_issue_rd_idx   (rd_idx),
        .i_issue_rd_we    (rd_we),
        .i_issue_rd_src   (rd_src),
        .i_issue_rs1_idx  (rs1_idx),
        .i_issue_rs2_idx  (rs2_idx),
        .i_issue_rs1_used (rs1_used),
        .i_issue_rs2_used (rs2_used),
        .i_wb_valid       (wb_valid),
        .i_wb_rd_idx      (wb_idx),
        .i_flush          (flush),
        .o_pending_mask   (pending_mask),
        .o_outstanding    (outstanding),
        .o_stall_raw      (stall_raw),
        .o_stall_waw      (stall_waw),
        .o_stall_csr      (stall_csr),
        .o_stall_full     (stall_full),
        .o_stall_src      (stall_src),
        .o_wb_err         (wb_err)
    );

    typedef struct {
        logic        rst;
        logic        valid;
        logic        we;
        logic [4:0]  rd;
        logic [1:0]  src;
        logic        rs1u;
        logic [4:0]  rs1;
        logic        rs2u;
        logic [4:0]  rs2;
        logic        wbv;
        logic [4:0]  wb;
        logic        flush;
        logic        e_rdy;
        logic        e_raw;
        logic        e_waw;
        logic        e_csr;
        logic        e_full;
        logic [1:0]  e_src;
        logic [31:0] e_mask;
        logic [4:0]  e_cnt;
        logic        e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic v, logic we, logic [4:0] rd, logic [1:0] src,
                                logic r1u, logic [4:0] r1, logic r2u, logic [4:0] r2,
                                logic wbv, logic [4:0] wb, logic fl,
                                logic rdy, logic raw, logic waw, logic cs, logic fu,
                                logic [1:0] ss, logic [31:0] mask, logic [4:0] cnt, logic err);
        vec_t t;
        t.rst = r; t.valid = v; t.we = we; t.rd = rd; t.src = src;
        t.rs1u = r1u; t.rs1 = r1; t.rs2u = r2u; t.rs2 = r2;
        t.wbv = wbv; t.wb = wb; t.flush = fl;
        t.e_rdy = rdy; t.e_raw = raw; t.e_waw = waw; t.e_csr = cs; t.e_full = fu;
        t.e_src = ss; t.e_mask = mask; t.e_cnt = cnt; t.e_err = err;
        return t;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, row, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        rst = t.rst; issue_valid = t.valid; rd_we = t.we; rd_idx = t.rd; rd_src = t.src;
        rs1_used = t.rs1u; rs1_idx = t.rs1; rs2_used = t.rs2u; rs2_idx = t.rs2;
        wb_valid = t.wbv; wb_idx = t.wb; flush = t.flush;
    endtask

    int lat;

    initial begin
        //            rst v we rd  src  r1u r1  r2u r2  wbv wb fl | rdy raw waw csr full ssrc mask        cnt err
        tbl.push_back(mk(1, 1, 1, 5,  LOAD, 0, 0,  0, 0,  0, 0,  0,  0, 0, 0, 0, 0, 0,    32'h0,      0, 0));
        tbl.push_back(mk(0, 1, 1, 5,  LOAD, 0, 0,  0, 0,  0, 0,  0,  1, 0, 0, 0, 0, 0,    32'h0,      0, 0));
        tbl.push_back(mk(0, 1, 1, 10, ALU,  1, 5,  0, 0,  0, 0,  0,  0, 1, 0, 0, 0, LOAD, 32'h20,     1, 0));
        tbl.push_back(mk(0, 1, 1, 10, ALU,  1, 5,  0, 0,  1, 5,  0,  0, 1, 0, 0, 0, LOAD, 32'h20,     1, 0));
        tbl.push_back(mk(0, 1, 1, 10, ALU,  1, 5,  0, 0,  0, 0,  0,  1, 0, 0, 0, 0, 0,    32'h0,      0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  ALU,  0, 0,  0, 0,  1, 10, 0,  1, 0, 0, 0, 0, 0,    32'h400,    1, 0));
        tbl.push_back(mk(0, 1, 1, 7,  ALU,  0, 0,  0, 0,  0, 0,  0,  1, 0, 0, 0, 0, 0,    32'h0,      0, 0));
        tbl.push_back(mk(0, 1, 1, 7,  ALU,  0, 0,  0, 0,  0, 0,  0,  0, 0, 1, 0, 0, 0,    32'h80,     1, 0));
        tbl.push_back(mk(0, 1, 1, 7,  ALU,  0, 0,  0, 0,  1, 7,  0,  0, 0, 1, 0, 0, 0,    32'h80,     1, 0));
        tbl.push_back(mk(0, 1, 1, 7,  ALU,  0, 0,  0, 0,  0, 0,  0,  1, 0, 0, 0, 0, 0,    32'h0,      0, 0));
        tbl.push_back(mk(0, 1, 1, 0,  ALU,  0, 0,  0, 0,  0, 0,  0,  1, 0, 0, 0, 0, 0,    32'h80,     1, 0));
        tbl.push_back(mk(0, 1, 0, 9,  ALU,  0, 0,  0, 0,  0, 0,  0,  1, 0, 0, 0, 0, 0,    32'h80,     1, 0));
        tbl.push_back(mk(0, 0, 0, 0,  ALU,  0, 0,  0, 0,  1, 7,  0,  1, 0, 0, 0, 0, 0,    32'h80,     1, 0));
        tbl.push_back(mk(0, 1, 1, 1,  ALU,  0, 0,  0, 0,  0, 0,  0,  1, 0, 0, 0, 0, 0,    32'h0,      0, 0));
        tbl.push_back(mk(0, 1, 1, 2,  ALU,  0, 0,  0, 0,  0, 0,  0,  1, 0, 0, 0, 0, 0,    32'h2,      1, 0));
        tbl.push_back(mk(0, 1, 1, 3,  ALU,  0, 0,  0, 0,  0, 0,  0,  1, 0, 0, 0, 0, 0,    32'h6,      2, 0));
        tbl.push_back(mk(0, 1, 1, 4,  ALU,  0, 0,  0, 0,  0, 0,  0,  1, 0, 0, 0, 0, 0,    32'hE,      3, 0));
        tbl.push_back(mk(0, 1, 1, 6,  ALU,  0, 0,  0, 0,  0, 0,  0,  0, 0, 0, 0, 1, 0,    32'h1E,     4, 0));
        tbl.push_back(mk(0, 1, 1, 6,  ALU,  0, 0,  0, 0,  1, 2,  0,  0, 0, 0, 0, 1, 0,    32'h1E,     4, 0));
        tbl.push_back(mk(0, 1, 1, 6,  ALU,  0, 0,  0, 0,  0, 0,  0,  1, 0, 0, 0, 0, 0,    32'h1A,     3, 0));
        tbl.push_back(mk(0, 0, 0, 0,  ALU,  0, 0,  0, 0,  1, 1,  0,  1, 0, 0, 0, 0, 0,    32'h5A,     4, 0));
        tbl.push_back(mk(0, 0, 0, 0,  ALU,  0, 0,  0, 0,  1, 4,  0,  1, 0, 0, 0, 0, 0,    32'h58,     3, 0));
        tbl.push_back(mk(0, 0, 0, 0,  ALU,  0, 0,  0, 0,  1, 6,  0,  1, 0, 0, 0, 0, 0,    32'h48,     2, 0));
        tbl.push_back(mk(0, 0, 0, 0,  ALU,  0, 0,  0, 0,  0, 0,  0,  1, 0, 0, 0, 0, 0,    32'h8,      1, 0));
        tbl.push_back(mk(0, 1, 1, 8,  CSR,  0, 0,  0, 0,  0, 0,  0,  0, 0, 0, 1, 0, 0,    32'h8,      1, 0));
        tbl.push_back(mk(0, 1, 1, 8,  CSR,  0, 0,  0, 0,  1, 3,  0,  0, 0, 0, 1, 0, 0,    32'h8,      1, 0));
        tbl.push_back(mk(0, 1, 1, 8,  CSR,  0, 0,  0, 0,  0, 0,  0,  1, 0, 0, 0, 0, 0,    32'h0,      0, 0));
        tbl.push_back(mk(0, 1, 1, 9,  ALU,  0, 0,  0, 0,  0, 0,  0,  0, 0, 0, 1, 0, 0,    32'h100,    1, 0));
        tbl.push_back(mk(0, 1, 1, 9,  ALU,  0, 0,  0, 0,  1, 8,  0,  0, 0, 0, 1, 0, 0,    32'h100,    1, 0));
        tbl.push_back(mk(0, 1, 1, 9,  ALU,  0, 0,  0, 0,  0, 0,  0,  1, 0, 0, 0, 0, 0,    32'h0,      0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  ALU,  0, 0,  0, 0,  1, 9,  0,  1, 0, 0, 0, 0, 0,    32'h200,    1, 0));
        tbl.push_back(mk(0, 0, 0, 0,  ALU,  0, 0,  0, 0,  0, 0,  0,  1, 0, 0, 0, 0, 0,    32'h0,      0, 0));
        tbl.push_back(mk(0, 1, 1, 11, ALU,  0, 0,  0, 0,  0, 0,  0,  1, 0, 0, 0, 0, 0,    32'h0,      0, 0));
        tbl.push_back(mk(0, 1, 1, 12, ALU,  0, 0,  0, 0,  0, 0,  0,  1, 0, 0, 0, 0, 0,    32'h800,    1, 0));
        tbl.push_back(mk(0, 1, 1, 13, ALU,  0, 0,  0, 0,  0, 0,  0,  1, 0, 0, 0, 0, 0,    32'h1800,   2, 0));
        tbl.push_back(mk(0, 1, 1, 14, ALU,  0, 0,  0, 0,  1, 11, 1,  0, 0, 0, 0, 0, 0,    32'h3800,   3, 0));
        tbl.push_back(mk(0, 0, 0, 0,  ALU,  0, 0,  0, 0,  0, 0,  0,  1, 0, 0, 0, 0, 0,    32'h0,      0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  ALU,  0, 0,  0, 0,  1, 12, 0,  1, 0, 0, 0, 0, 0,    32'h0,      0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  ALU,  0, 0,  0, 0,  1, 0,  0,  1, 0, 0, 0, 0, 0,    32'h0,      0, 1));
        tbl.push_back(mk(0, 0, 0, 0,  ALU,  0, 0,  0, 0,  0, 0,  0,  1, 0, 0, 0, 0, 0,    32'h0,      0, 1));
        tbl.push_back(mk(0, 1, 1, 5,  ALU,  0, 0,  0, 0,  0, 0,  0,  1, 0, 0, 0, 0, 0,    32'h0,      0, 0));
        tbl.push_back(mk(1, 1, 1, 6,  ALU,  0, 0,  0, 0,  0, 0,  0,  0, 0, 0, 0, 0, 0,    32'h20,     1, 0));
        tbl.push_back(mk(0, 1, 1, 20, LOAD, 0, 0,  0, 0,  0, 0,  0,  1, 0, 0, 0, 0, 0,    32'h0,      0, 0));
        tbl.push_back(mk(0, 1, 1, 21, PC4,  0, 0,  0, 0,  0, 0,  0,  1, 0, 0, 0, 0, 0,    32'h100000, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0,  ALU,  0, 20, 1, 21, 0, 0,  0,  0, 1, 0, 0, 0, PC4,  32'h300000, 2, 0));
        tbl.push_back(mk(0, 1, 0, 0,  ALU,  1, 20, 1, 21, 0, 0,  0,  0, 1, 0, 0, 0, LOAD, 32'h300000, 2, 0));
        tbl.push_back(mk(0, 1, 0, 0,  ALU,  1, 0,  1, 0,  0, 0,  0,  1, 0, 0, 0, 0, 0,    32'h300000, 2, 0));

        rst = 1'b1; issue_valid = 1'b0; rd_we = 1'b0; rd_idx = 5'd0; rd_src = ALU;
        rs1_used = 1'b0; rs1_idx = 5'd0; rs2_used = 1'b0; rs2_idx = 5'd0;
        wb_valid = 1'b0; wb_idx = 5'd0; flush = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            chk("ready",      i, 32'(issue_ready),  32'(tbl[i].e_rdy));
            chk("stall_raw",  i, 32'(stall_raw),    32'(tbl[i].e_raw));
            chk("stall_waw",  i, 32'(stall_waw),    32'(tbl[i].e_waw));
            chk("stall_csr",  i, 32'(stall_csr),    32'(tbl[i].e_csr));
            chk("stall_full", i, 32'(stall_full),   32'(tbl[i].e_full));
            chk("stall_src",  i, 32'(stall_src),    32'(tbl[i].e_src));
            chk("mask",       i, pending_mask,      tbl[i].e_mask);
            chk("count",      i, 32'(outstanding),  32'(tbl[i].e_cnt));
            chk("wb_err",     i, 32'(wb_err),       32'(tbl[i].e_err));
        end

        // x20 (LOAD) and x21 (PC4) still pending: a consumer of x20 waits for its writeback
        @(negedge clk);
        issue_valid = 1'b1; rd_we = 1'b0; rd_idx = 5'd0; rs1_used = 1'b1; rs1_idx = 5'd20;
        rs2_used = 1'b0; rs2_idx = 5'd0; wb_valid = 1'b0; flush = 1'b0;
        #1;
        chk("dep_blocked", 100, 32'(issue_ready), 32'd0);
        @(negedge clk);
        wb_valid = 1'b1; wb_idx = 5'd20;
        #1;
        chk("dep_wb_cycle", 101, 32'(issue_ready), 32'd0);
        lat = 0;
        do begin
            @(negedge clk);
            wb_valid = 1'b0;
            #1;
            lat++;
        end while (!issue_ready && lat < 8);
        chk("dep_latency", 102, 32'(lat), 32'd1);
        @(negedge clk);
        issue_valid = 1'b0; rs1_used = 1'b0;
        #1;
        chk("dep_mask", 103, pending_mask, 32'h200000);
        chk("dep_count", 104, 32'(outstanding), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
